// File: rtl/idma_desc64_addr_arbiter_if.sv
// Bundle of the arbiter's submitter-side, descriptor-FIFO-side and completion signals.
// The arbiter connects through the slave modport; whoever drives it uses master.
interface idma_desc64_addr_arbiter_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdDepth   = 8
);
    localparam int unsigned CntWidth = $clog2(IdDepth + 1);

    logic [NumReq*AddrWidth-1:0] req_addr_i;
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [AddrWidth-1:0]        addr_o;
    logic                        addr_valid_o;
    logic                        addr_ready_i;
    logic                        done_i;
    logic [NumReq-1:0]           done_o;
    logic                        spurious_o;
    logic [CntWidth-1:0]         inflight_o;
    logic                        busy_o;

    modport slave (
        input  req_addr_i, req_valid_i, addr_ready_i, done_i,
        output req_ready_o, addr_o, addr_valid_o, done_o, spurious_o, inflight_o, busy_o
    );

    modport master (
        output req_addr_i, req_valid_i, addr_ready_i, done_i,
        input  req_ready_o, addr_o, addr_valid_o, done_o, spurious_o, inflight_o, busy_o
    );
endinterface

// File: rtl/idma_desc64_addr_arbiter.sv
// Round-robin arbiter sharing the desc64 descriptor-address input between NumReq
// submitters. Granted addresses go through a one-entry output slot; an in-order ID
// FIFO remembers the owner of every granted descriptor so completion pulses can be
// routed back to the right submitter.
module idma_desc64_addr_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdDepth   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    idma_desc64_addr_arbiter_if.slave  bus
);
    localparam int unsigned IdxWidth = $clog2(NumReq);
    localparam int unsigned PtrWidth = $clog2(IdDepth);
    localparam int unsigned CntWidth = $clog2(IdDepth + 1);

    // Output slot and round-robin state
    logic [AddrWidth-1:0] addr_reg;
    logic                 addr_valid_reg;
    logic [IdxWidth-1:0]  ptr_reg;

    // ID FIFO
    logic [IdxWidth-1:0]  id_mem [IdDepth];
    logic [PtrWidth-1:0]  wr_ptr_reg;
    logic [PtrWidth-1:0]  rd_ptr_reg;
    logic [CntWidth-1:0]  count_reg;

    // Completion pulses
    logic [NumReq-1:0]    done_reg;
    logic [NumReq-1:0]    done_next;
    logic                 spurious_reg;

    logic [AddrWidth-1:0] port_addr [NumReq];
    logic [IdxWidth-1:0]  winner;
    logic                 found;
    logic                 slot_free;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 grant;
    logic                 pop;
    logic [IdxWidth-1:0]  head_id;
    logic [PtrWidth-1:0]  wr_ptr_inc;
    logic [PtrWidth-1:0]  rd_ptr_inc;

    // Unpack the flat address bus and build the one-hot ready / completion vectors
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
        assign port_addr[gi]       = bus.req_addr_i[gi*AddrWidth +: AddrWidth];
        assign bus.req_ready_o[gi] = grant && (winner == IdxWidth'(gi));
        assign done_next[gi]       = pop && (head_id == IdxWidth'(gi));
    end

    // Winner search: first valid port starting one past the last winner, with wrap
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= int'(NumReq); k++) begin
            idx = (int'(ptr_reg) + k) % int'(NumReq);
            if (!found && bus.req_valid_i[IdxWidth'(idx)]) begin
                found  = 1'b1;
                winner = IdxWidth'(idx);
            end
        end
    end

    // A full FIFO blocks grants even if a completion pops it this cycle; reset
    // also masks the grant so req_ready_o reads zero while held in reset.
    assign slot_free  = !addr_valid_reg || bus.addr_ready_i;
    assign fifo_full  = (count_reg == CntWidth'(IdDepth));
    assign fifo_empty = (count_reg == '0);
    assign grant      = rst_ni && slot_free && !fifo_full && found;
    assign pop        = bus.done_i && !fifo_empty;
    assign head_id    = id_mem[rd_ptr_reg];
    assign wr_ptr_inc = (wr_ptr_reg == PtrWidth'(IdDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_inc = (rd_ptr_reg == PtrWidth'(IdDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;

    // Output slot: load on grant, drain on handshake, otherwise hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_reg       <= '0;
            addr_valid_reg <= 1'b0;
            ptr_reg        <= IdxWidth'(NumReq - 1);
        end else if (grant) begin
            addr_reg       <= port_addr[winner];
            addr_valid_reg <= 1'b1;
            ptr_reg        <= winner;
        end else if (bus.addr_ready_i) begin
            addr_valid_reg <= 1'b0;
        end
    end

    // ID storage: no reset needed, entries are only read while counted as valid
    always_ff @(posedge clk_i) begin
        if (grant) begin
            id_mem[wr_ptr_reg] <= winner;
        end
    end

    // ID FIFO pointers and fill level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (grant) begin
                wr_ptr_reg <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({grant, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered one-cycle completion and spurious pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_reg     <= '0;
            spurious_reg <= 1'b0;
        end else begin
            done_reg     <= done_next;
            spurious_reg <= bus.done_i && fifo_empty;
        end
    end

    assign bus.addr_o       = addr_reg;
    assign bus.addr_valid_o = addr_valid_reg;
    assign bus.done_o       = done_reg;
    assign bus.spurious_o   = spurious_reg;
    assign bus.inflight_o   = count_reg;
    assign bus.busy_o       = (count_reg != '0) || addr_valid_reg;
endmodule

// File: tb/tb_idma_desc64_addr_arbiter.sv
// Scoreboard bench for idma_desc64_addr_arbiter: a stimulus process drives directed and
// random traffic and feeds a queue-based reference model; a monitor on the falling edge
// pops expected addresses/completions and checks the per-cycle status outputs.
module tb_idma_desc64_addr_arbiter;
    localparam int NR    = 4;
    localparam int AW    = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    idma_desc64_addr_arbiter_if #(.NumReq(NR), .AddrWidth(AW), .IdDepth(DEPTH)) bus ();

    idma_desc64_addr_arbiter #(.NumReq(NR), .AddrWidth(AW), .IdDepth(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int              m_owner[$];
    bit              m_slot_valid;
    int              m_last;
    logic [NR-1:0]   m_done_next;
    bit              m_spur_next;
    logic [AW-1:0]   addr_q[$];
    logic [NR-1:0]   done_q[$];
    logic [AW-1:0]   addrs[NR];

    // Expectations for the cycle currently being driven
    logic [NR-1:0]   cur_ready;
    int              cur_inflight;
    bit              cur_slot;
    bit              cur_spur;
    logic [NR-1:0]   cur_done;
    bit              chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner.delete();
        addr_q.delete();
        done_q.delete();
        m_slot_valid = 1'b0;
        m_last       = NR - 1;
        m_done_next  = '0;
        m_spur_next  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'd0);
        check({tag, "_addr"}, bus.addr_o, 64'd0);
        check({tag, "_addr_valid"}, 64'(bus.addr_valid_o), 64'd0);
        check({tag, "_done"}, 64'(bus.done_o), 64'd0);
        check({tag, "_spurious"}, 64'(bus.spurious_o), 64'd0);
        check({tag, "_inflight"}, 64'(bus.inflight_o), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    endtask

    // One clock cycle of stimulus plus the model's view of that cycle
    task automatic step(input logic [NR-1:0] v, input logic rdy, input logic dn);
        int w;
        int p;
        int h;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            addrs[i] = {$urandom, $urandom};
            bus.req_addr_i[i*AW +: AW] = addrs[i];
        end
        bus.req_valid_i  = v;
        bus.addr_ready_i = rdy;
        bus.done_i       = dn;

        cur_inflight = m_owner.size();
        cur_slot     = m_slot_valid;
        cur_spur     = m_spur_next;
        cur_done     = m_done_next;

        w = -1;
        if ((!m_slot_valid || rdy) && m_owner.size() < DEPTH) begin
            for (int k = 1; k <= NR; k++) begin
                p = (m_last + k) % NR;
                if (v[p]) begin
                    w = p;
                    break;
                end
            end
        end
        cur_ready = (w >= 0) ? (NR'(1) << w) : '0;

        m_done_next = '0;
        m_spur_next = 1'b0;
        if (dn) begin
            if (m_owner.size() > 0) begin
                h = m_owner.pop_front();
                m_done_next = NR'(1) << h;
                done_q.push_back(NR'(1) << h);
            end else begin
                m_spur_next = 1'b1;
            end
        end

        if (w >= 0) begin
            m_owner.push_back(w);
            m_slot_valid = 1'b1;
            m_last       = w;
            addr_q.push_back(addrs[w]);
        end else if (rdy) begin
            m_slot_valid = 1'b0;
        end
        chk_en = 1'b1;
    endtask

    // Monitor: scoreboard pops on DUT activity plus per-cycle status checks
    always @(negedge clk) begin
        if (chk_en) begin
            logic [AW-1:0] ea;
            logic [NR-1:0] ed;
            check("req_ready", 64'(bus.req_ready_o), 64'(cur_ready));
            check("inflight", 64'(bus.inflight_o), 64'(cur_inflight));
            check("addr_valid", 64'(bus.addr_valid_o), 64'(cur_slot));
            check("busy", 64'(bus.busy_o), 64'(cur_inflight != 0 || cur_slot));
            check("spurious", 64'(bus.spurious_o), 64'(cur_spur));
            check("done_pulse", 64'(bus.done_o), 64'(cur_done));
            if (bus.addr_valid_o && bus.addr_ready_i) begin
                if (addr_q.size() == 0) begin
                    check("addr_unexpected", 64'd1, 64'd0);
                end else begin
                    ea = addr_q.pop_front();
                    check("addr_handshake", bus.addr_o, ea);
                end
            end
            if (bus.done_o != '0) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'(bus.done_o), 64'd0);
                end else begin
                    ed = done_q.pop_front();
                    check("done_route", 64'(bus.done_o), 64'(ed));
                end
            end
        end
    end

    initial begin
        bus.req_addr_i   = '0;
        bus.req_valid_i  = '1;
        bus.addr_ready_i = 1'b0;
        bus.done_i       = 1'b0;
        model_reset();

        // Held in reset with every port requesting
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        bus.req_valid_i = '0;
        rst_n = 1'b1;

        // Round robin, all ports valid
        repeat (5) step('1, 1'b1, 1'b0);
        // Backpressure, then release
        repeat (5) step('1, 1'b0, 1'b0);
        repeat (4) step('1, 1'b1, 1'b0);
        // FIFO full: a pop does not unblock in the same cycle
        step('1, 1'b1, 1'b1);
        step('1, 1'b1, 1'b0);
        // Drain including spurious completions
        repeat (12) step('0, 1'b1, 1'b1);
        // Routing to ports 2, 0, 3
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        repeat (3) step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b0);
        // Simultaneous grant and completion with three in flight
        repeat (3) step('1, 1'b1, 1'b0);
        step('1, 1'b1, 1'b1);
        repeat (4) step('0, 1'b1, 1'b1);

        // Random traffic with heavy and light completion rates
        for (int i = 0; i < 300; i++)
            step(NR'($urandom), 1'(($urandom % 10) < 7), 1'(($urandom % 10) < 3));
        for (int i = 0; i < 200; i++)
            step(NR'($urandom), 1'(($urandom % 10) < 5), 1'(($urandom % 10) < 6));

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        bus.req_valid_i = '1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        bus.req_valid_i = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++)
            step(NR'($urandom), 1'(($urandom % 10) < 7), 1'(($urandom % 10) < 4));

        // Flush everything outstanding
        repeat (12) step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("final_done_q_empty", 64'(done_q.size()), 64'd0);
        check("final_addr_q_empty", 64'(addr_q.size()), 64'd0);
        check("final_inflight", 64'(bus.inflight_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
